// File: rtl/ram_arbiter_if.sv
// Bus bundle between the three RAM requesters, the arbiter and the RAM
// command port. The slave modport is the arbiter's view; master is the
// view of the environment that drives requests and models the RAM.
interface ram_arbiter_if;
  // external loader / debug port
  logic        x_req;
  logic        x_we;
  logic [15:0] x_addr;
  logic [31:0] x_wdata;
  logic [2:0]  x_size;
  logic        x_ack;
  logic        x_err;
  logic [31:0] x_rdata;
  // core load/store port
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_size;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  // core instruction fetch port
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [31:0] i_rdata;
  // RAM command port
  logic        ram_en;
  logic        ram_read_flag;
  logic        ram_write_flag;
  logic [15:0] ram_read_addr;
  logic [15:0] ram_write_addr;
  logic [31:0] ram_write_data;
  logic [2:0]  ram_write_size;
  logic [31:0] ram_read_data;
  // status
  logic        busy;
  logic [1:0]  grant;

  modport slave (
    input  x_req, x_we, x_addr, x_wdata, x_size,
    output x_ack, x_err, x_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    output d_ack, d_err, d_rdata,
    input  i_req, i_addr,
    output i_ack, i_err, i_rdata,
    output ram_en, ram_read_flag, ram_write_flag,
    output ram_read_addr, ram_write_addr, ram_write_data, ram_write_size,
    input  ram_read_data,
    output busy, grant
  );

  modport master (
    output x_req, x_we, x_addr, x_wdata, x_size,
    input  x_ack, x_err, x_rdata,
    output d_req, d_we, d_addr, d_wdata, d_size,
    input  d_ack, d_err, d_rdata,
    output i_req, i_addr,
    input  i_ack, i_err, i_rdata,
    input  ram_en, ram_read_flag, ram_write_flag,
    input  ram_read_addr, ram_write_addr, ram_write_data, ram_write_size,
    output ram_read_data,
    input  busy, grant
  );
endinterface

// File: rtl/ram_arbiter.sv
// Three-way arbiter/sequencer for the shared 64 KiB RAM command port.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among requesters
// ACCESS | one-cycle RAM command from the latched request
// RESP   | ack/err to the winner; arbitrate the next transaction
//
// Priority x > d > i, except fetch is forced through once it has lost
// STARVE_LIMIT arbitrations in a row. A requester is not eligible in
// its own RESP cycle, so one port alone gets at most one access per
// three cycles.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [15:0] ADDR_TOP     = 16'hFFFE
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  localparam logic [2:0] STORE_B = 3'd0;
  localparam logic [2:0] STORE_H = 3'd1;
  localparam logic [2:0] STORE_W = 3'd2;

  localparam logic [1:0] G_X    = 2'd0;
  localparam logic [1:0] G_D    = 2'd1;
  localparam logic [1:0] G_I    = 2'd2;
  localparam logic [1:0] G_NONE = 2'd3;

  localparam logic [3:0] W_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_grant;
  logic        r_we;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_err;
  logic [3:0]  r_starve;
  logic [31:0] r_x_rdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_i_rdata;

  logic        w_arb;
  logic        w_x_elig;
  logic        w_d_elig;
  logic        w_i_elig;
  logic [1:0]  w_win;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [2:0]  w_sel_size;
  logic [16:0] w_len;
  logic [16:0] w_end;
  logic        w_size_bad;
  logic        w_sel_err;
  logic [31:0] w_cap;
  logic        w_access_ok;

  // Eligibility, winner selection and the winner's command fields.
  always_comb begin
    w_arb    = (r_state == ST_IDLE) || (r_state == ST_RESP);
    w_x_elig = w_arb && bus.x_req && !(r_state == ST_RESP && r_grant == G_X);
    w_d_elig = w_arb && bus.d_req && !(r_state == ST_RESP && r_grant == G_D);
    w_i_elig = w_arb && bus.i_req && !(r_state == ST_RESP && r_grant == G_I);

    w_win = G_NONE;
    if (w_i_elig && (r_starve == W_LIMIT)) w_win = G_I;
    else if (w_x_elig)                     w_win = G_X;
    else if (w_d_elig)                     w_win = G_D;
    else if (w_i_elig)                     w_win = G_I;

    w_sel_we    = 1'b0;
    w_sel_addr  = bus.i_addr;
    w_sel_wdata = 32'd0;
    w_sel_size  = STORE_W;
    case (w_win)
      G_X: begin
        w_sel_we    = bus.x_we;
        w_sel_addr  = bus.x_addr;
        w_sel_wdata = bus.x_wdata;
        w_sel_size  = bus.x_size;
      end
      G_D: begin
        w_sel_we    = bus.d_we;
        w_sel_addr  = bus.d_addr;
        w_sel_wdata = bus.d_wdata;
        w_sel_size  = bus.d_size;
      end
      default: ;
    endcase

    // Unknown size codes are only fatal for writes; reads return a word.
    w_size_bad = 1'b0;
    case (w_sel_size)
      STORE_B: w_len = 17'd1;
      STORE_H: w_len = 17'd2;
      STORE_W: w_len = 17'd4;
      default: begin
        w_len      = 17'd4;
        w_size_bad = w_sel_we;
      end
    endcase
    w_end     = {1'b0, w_sel_addr} + w_len - 17'd1;
    w_sel_err = w_size_bad || (w_end > {1'b0, ADDR_TOP});
  end

  // Next-state decode.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next_state = (w_win != G_NONE) ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = (w_win != G_NONE) ? ST_ACCESS : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Command register, loaded from the winner at every arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= G_NONE;
      r_we    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 32'd0;
      r_size  <= 3'd0;
      r_err   <= 1'b0;
    end else if (w_arb) begin
      r_grant <= w_win;
      if (w_win != G_NONE) begin
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_size  <= w_sel_size;
        r_err   <= w_sel_err;
      end
    end
  end

  // Fetch starvation counter: counts consecutive lost arbitrations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= 4'd0;
    end else if (w_i_elig) begin
      if (w_win == G_I)            r_starve <= 4'd0;
      else if (r_starve != W_LIMIT) r_starve <= r_starve + 4'd1;
    end
  end

  // Error transactions and writes return zero read data.
  always_comb begin
    w_cap = (!r_we && !r_err) ? bus.ram_read_data : 32'd0;
  end

  // Per-port response data, updated at the end of ACCESS so it lines up with ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_rdata <= 32'd0;
      r_d_rdata <= 32'd0;
      r_i_rdata <= 32'd0;
    end else if (r_state == ST_ACCESS) begin
      case (r_grant)
        G_X:     r_x_rdata <= w_cap;
        G_D:     r_d_rdata <= w_cap;
        G_I:     r_i_rdata <= w_cap;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset removes strobes and acks immediately.
  always_comb begin
    w_access_ok        = (r_state == ST_ACCESS) && !r_err;
    bus.ram_en         = w_access_ok;
    bus.ram_read_flag  = w_access_ok && !r_we;
    bus.ram_write_flag = w_access_ok && r_we;
    bus.ram_read_addr  = bus.ram_read_flag  ? r_addr  : 16'd0;
    bus.ram_write_addr = bus.ram_write_flag ? r_addr  : 16'd0;
    bus.ram_write_data = bus.ram_write_flag ? r_wdata : 32'd0;
    bus.ram_write_size = bus.ram_write_flag ? r_size  : 3'd0;

    bus.x_ack   = (r_state == ST_RESP) && (r_grant == G_X);
    bus.d_ack   = (r_state == ST_RESP) && (r_grant == G_D);
    bus.i_ack   = (r_state == ST_RESP) && (r_grant == G_I);
    bus.x_err   = bus.x_ack && r_err;
    bus.d_err   = bus.d_ack && r_err;
    bus.i_err   = bus.i_ack && r_err;
    bus.x_rdata = r_x_rdata;
    bus.d_rdata = r_d_rdata;
    bus.i_rdata = r_i_rdata;

    bus.busy  = (r_state != ST_IDLE);
    bus.grant = (r_state == ST_IDLE) ? G_NONE : r_grant;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-wide little-endian RAM model.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [7:0]  mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  ram_arbiter_if bus ();

  ram_arbiter #(.STARVE_LIMIT(4), .ADDR_TOP(16'hFFFE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational read port
  assign bus.ram_read_data = {mem[bus.ram_read_addr + 16'd3], mem[bus.ram_read_addr + 16'd2],
                              mem[bus.ram_read_addr + 16'd1], mem[bus.ram_read_addr]};

  // write port plus bench preload
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus.ram_write_flag) begin
      mem[bus.ram_write_addr] <= bus.ram_write_data[7:0];
      if (bus.ram_write_size != 3'd0) mem[bus.ram_write_addr + 16'd1] <= bus.ram_write_data[15:8];
      if (bus.ram_write_size == 3'd2) begin
        mem[bus.ram_write_addr + 16'd2] <= bus.ram_write_data[23:16];
        mem[bus.ram_write_addr + 16'd3] <= bus.ram_write_data[31:24];
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      pl_addr = a + 16'(b);
      pl_data = w[8*b +: 8];
      pl_we   = 1'b1;
      step();
    end
    pl_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_g [11];
  logic [2:0] exp_ack;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    pl_we = 1'b0; pl_addr = 16'd0; pl_data = 8'd0;
    bus.x_req = 0; bus.x_we = 0; bus.x_addr = 0; bus.x_wdata = 0; bus.x_size = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_size = 0;
    bus.i_req = 0; bus.i_addr = 0;
    exp_g = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};

    // reset state
    step(); step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 3);
    chk("rst_acks", {bus.x_ack, bus.d_ack, bus.i_ack}, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    @(negedge clk) rst = 1'b1;
    step();

    preload(16'h0000, 32'h00000013);
    preload(16'h0010, 32'h44332211);
    preload(16'h0020, 32'hDDCCBBAA);
    preload(16'h0030, 32'h04030201);
    preload(16'h0100, 32'h00000000);
    preload(16'h0200, 32'h5A5A5A5A);

    // single fetch
    bus.i_req = 1; bus.i_addr = 16'h0000;
    step();
    chk("f_busy", bus.busy, 1);
    chk("f_rd_flag", bus.ram_read_flag, 1);
    chk("f_rd_addr", bus.ram_read_addr, 0);
    chk("f_grant", bus.grant, 2);
    chk("f_ack_early", bus.i_ack, 0);
    step();
    chk("f_ack", bus.i_ack, 1);
    chk("f_rdata", bus.i_rdata, 32'h00000013);
    chk("f_err", bus.i_err, 0);
    bus.i_req = 0;
    step();
    chk("f_ack_pulse", bus.i_ack, 0);
    chk("f_idle_grant", bus.grant, 3);
    chk("f_rdata_hold", bus.i_rdata, 32'h00000013);

    // store halfword then load word, same requester
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0102; bus.d_wdata = 32'h0000BEEF; bus.d_size = 3'd1;
    step();
    chk("st_wr_flag", bus.ram_write_flag, 1);
    chk("st_wr_size", bus.ram_write_size, 1);
    chk("st_wr_addr", bus.ram_write_addr, 16'h0102);
    chk("st_wr_data", bus.ram_write_data, 32'h0000BEEF);
    step();
    chk("st_ack", bus.d_ack, 1);
    chk("st_wr_one_cycle", bus.ram_write_flag, 0);
    chk("st_rdata", bus.d_rdata, 0);
    bus.d_we = 0; bus.d_addr = 16'h0100; bus.d_size = 3'd2;
    step();
    chk("ld_gap_idle", bus.busy, 0);
    chk("ld_gap_ack", bus.d_ack, 0);
    step();
    chk("ld_rd_flag", bus.ram_read_flag, 1);
    step();
    chk("ld_ack", bus.d_ack, 1);
    chk("ld_rdata", bus.d_rdata, 32'hBEEF0000);
    bus.d_req = 0;
    step();

    // priority: all three at once
    bus.x_req = 1; bus.x_we = 0; bus.x_addr = 16'h0010; bus.x_size = 3'd2;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0020; bus.d_size = 3'd2;
    bus.i_req = 1; bus.i_addr = 16'h0030;
    step();
    chk("pr_g0", bus.grant, 0);
    step();
    chk("pr_xack", {bus.x_ack, bus.d_ack, bus.i_ack}, 3'b100);
    chk("pr_xrdata", bus.x_rdata, 32'h44332211);
    bus.x_req = 0;
    step();
    chk("pr_g1", bus.grant, 1);
    step();
    chk("pr_dack", {bus.x_ack, bus.d_ack, bus.i_ack}, 3'b010);
    chk("pr_drdata", bus.d_rdata, 32'hDDCCBBAA);
    bus.d_req = 0;
    step();
    chk("pr_g2", bus.grant, 2);
    step();
    chk("pr_iack", {bus.x_ack, bus.d_ack, bus.i_ack}, 3'b001);
    chk("pr_irdata", bus.i_rdata, 32'h04030201);
    bus.i_req = 0;
    step();
    chk("pr_idle", bus.busy, 0);

    // starvation: x and d keep alternating, fetch forced at the 5th arbitration
    bus.x_req = 1; bus.d_req = 1; bus.i_req = 1;
    for (int k = 0; k < 11; k++) begin
      step();
      chk($sformatf("sv_grant%0d", k), bus.grant, exp_g[k]);
      step();
      case (exp_g[k])
        2'd0:    exp_ack = 3'b100;
        2'd1:    exp_ack = 3'b010;
        default: exp_ack = 3'b001;
      endcase
      chk($sformatf("sv_ack%0d", k), {bus.x_ack, bus.d_ack, bus.i_ack}, exp_ack);
    end
    bus.x_req = 0; bus.d_req = 0; bus.i_req = 0;
    step();
    chk("sv_idle", bus.busy, 0);

    // range error on fetch word at FFFD
    bus.i_req = 1; bus.i_addr = 16'hFFFD;
    step();
    chk("re_busy", bus.busy, 1);
    chk("re_no_en", bus.ram_en, 0);
    chk("re_no_rd", bus.ram_read_flag, 0);
    step();
    chk("re_ack", bus.i_ack, 1);
    chk("re_err", bus.i_err, 1);
    chk("re_rdata", bus.i_rdata, 0);
    bus.i_req = 0;
    step();
    chk("re_err_pulse", bus.i_err, 0);

    // byte write at top address is legal
    bus.x_req = 1; bus.x_we = 1; bus.x_addr = 16'hFFFE; bus.x_wdata = 32'h000000A5; bus.x_size = 3'd0;
    step();
    chk("tb_wr_flag", bus.ram_write_flag, 1);
    chk("tb_wr_addr", bus.ram_write_addr, 16'hFFFE);
    step();
    chk("tb_ack", bus.x_ack, 1);
    chk("tb_err", bus.x_err, 0);
    chk("tb_rdata", bus.x_rdata, 0);
    chk("tb_mem", {24'd0, mem[16'hFFFE]}, 32'h000000A5);
    bus.x_req = 0;
    step();

    // undefined size code on a write
    bus.x_req = 1; bus.x_we = 1; bus.x_addr = 16'h0040; bus.x_size = 3'd5;
    step();
    chk("bs_no_wr", bus.ram_write_flag, 0);
    step();
    chk("bs_ack", bus.x_ack, 1);
    chk("bs_err", bus.x_err, 1);
    bus.x_req = 0;
    step();

    // reset during ACCESS of a d write
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_wdata = 32'hDEADBEEF; bus.d_size = 3'd2;
    step();
    chk("ra_wr_flag", bus.ram_write_flag, 1);
    #2 rst = 1'b0;
    #1;
    chk("ra_flag_drop", bus.ram_write_flag, 0);
    chk("ra_busy", bus.busy, 0);
    chk("ra_grant", bus.grant, 3);
    bus.d_req = 0;
    step();
    chk("ra_mem", {bus.ram_write_flag, mem[16'h0200]}, {1'b0, 8'h5A});
    @(negedge clk) rst = 1'b1;
    step();
    chk("ra_no_ack", bus.d_ack, 0);
    step();
    chk("ra_no_ack2", bus.d_ack, 0);
    chk("ra_idle", bus.busy, 0);
    chk("ra_d_rdata", bus.d_rdata, 0);
    chk("ra_mem_word", {mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]}, 32'h5A5A5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
